// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared opcode encodings and load/store decode helpers for
//                the MEM pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int OP_CODE_LEN = 8;

    localparam logic [OP_CODE_LEN-1:0] c_OP_NOP = 8'h00;
    localparam logic [OP_CODE_LEN-1:0] c_OP_ADD = 8'h01;
    localparam logic [OP_CODE_LEN-1:0] c_OP_LB  = 8'h20;
    localparam logic [OP_CODE_LEN-1:0] c_OP_LH  = 8'h21;
    localparam logic [OP_CODE_LEN-1:0] c_OP_LW  = 8'h22;
    localparam logic [OP_CODE_LEN-1:0] c_OP_LBU = 8'h24;
    localparam logic [OP_CODE_LEN-1:0] c_OP_LHU = 8'h25;
    localparam logic [OP_CODE_LEN-1:0] c_OP_SB  = 8'h28;
    localparam logic [OP_CODE_LEN-1:0] c_OP_SH  = 8'h29;
    localparam logic [OP_CODE_LEN-1:0] c_OP_SW  = 8'h2A;

    function automatic logic op_is_load(input logic [OP_CODE_LEN-1:0] op);
        return (op == c_OP_LB) || (op == c_OP_LH) || (op == c_OP_LW) ||
               (op == c_OP_LBU) || (op == c_OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [OP_CODE_LEN-1:0] op);
        return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
    endfunction

    // Number of bytes moved by a memory op; zero for anything else.
    function automatic logic [2:0] op_size(input logic [OP_CODE_LEN-1:0] op);
        logic [2:0] v_size;
        v_size = 3'd0;
        case (op)
            c_OP_LB, c_OP_LBU, c_OP_SB: v_size = 3'd1;
            c_OP_LH, c_OP_LHU, c_OP_SH: v_size = 3'd2;
            c_OP_LW, c_OP_SW:           v_size = 3'd4;
            default:                    v_size = 3'd0;
        endcase
        return v_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Non-memory ops pass straight through;
//                loads/stores are serialised into byte accesses on a simple
//                req/gnt memory port while the pipeline is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_CODE_LEN-1:0] aluop_i,
    input  logic [31:0]            rd_data_i,
    input  logic [4:0]             rd_addr_i,
    input  logic                   rd_enable_i,
    input  logic [31:0]            mem_addr_i,
    input  logic                   stall_i,
    output logic [31:0]            rd_data_o,
    output logic [4:0]             rd_addr_o,
    output logic                   rd_enable_o,
    output logic                   stall_req_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [31:0]            mem_a_o,
    output logic [7:0]             mem_dout_o,
    input  logic [7:0]             mem_din_i,
    input  logic                   mem_gnt_i
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_WAIT   = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_issue;     // bytes granted so far
    logic [2:0]  r_recv;      // read bytes captured so far (also the lane index)
    logic        r_rd_pend;   // a read was granted last cycle; its byte is on mem_din_i now
    logic [31:0] r_buf;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [2:0]  w_size;
    logic        w_last;
    logic        w_grant;
    logic [31:0] w_load_ext;

    assign w_is_load  = op_is_load(aluop_i);
    assign w_is_store = op_is_store(aluop_i);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_size     = op_size(aluop_i);
    assign w_last     = (r_issue == (w_size - 3'd1));
    assign w_grant    = (r_state == c_S_ACCESS) && mem_gnt_i;

    // Sequencer: issue bytes, collect read data, hold the result until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_issue   <= 3'd0;
            r_recv    <= 3'd0;
            r_rd_pend <= 1'b0;
            r_buf     <= 32'd0;
        end else begin
            r_rd_pend <= w_grant & w_is_load;
            if (r_rd_pend) begin
                r_buf[{r_recv[1:0], 3'b000} +: 8] <= mem_din_i;
                r_recv <= r_recv + 3'd1;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_is_mem) begin
                        r_state <= c_S_ACCESS;
                        r_issue <= 3'd0;
                        r_recv  <= 3'd0;
                        r_buf   <= 32'd0;
                    end
                end
                c_S_ACCESS: begin
                    if (mem_gnt_i) begin
                        r_issue <= r_issue + 3'd1;
                        if (w_last) begin
                            // A load still has its final byte in flight.
                            r_state <= w_is_load ? c_S_WAIT : c_S_DONE;
                        end
                    end
                end
                c_S_WAIT: begin
                    r_state <= c_S_DONE;
                end
                c_S_DONE: begin
                    if (!stall_i) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Lane extension of the assembled load data.
    always_comb begin
        w_load_ext = r_buf;
        case (aluop_i)
            c_OP_LB:  w_load_ext = {{24{r_buf[7]}}, r_buf[7:0]};
            c_OP_LH:  w_load_ext = {{16{r_buf[15]}}, r_buf[15:0]};
            c_OP_LBU: w_load_ext = {24'd0, r_buf[7:0]};
            c_OP_LHU: w_load_ext = {16'd0, r_buf[15:0]};
            default:  w_load_ext = r_buf;
        endcase
    end

    // Output decode from state; everything is forced quiet while in reset.
    always_comb begin
        rd_data_o   = 32'd0;
        rd_addr_o   = 5'd0;
        rd_enable_o = 1'b0;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_a_o     = 32'd0;
        mem_dout_o  = 8'd0;
        if (!rst) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_is_mem) begin
                        stall_req_o = 1'b1;
                        rd_addr_o   = rd_addr_i;
                    end else begin
                        rd_data_o   = rd_data_i;
                        rd_addr_o   = rd_addr_i;
                        rd_enable_o = rd_enable_i;
                    end
                end
                c_S_ACCESS: begin
                    stall_req_o = 1'b1;
                    rd_addr_o   = rd_addr_i;
                    mem_req_o   = 1'b1;
                    mem_we_o    = w_is_store;
                    mem_a_o     = mem_addr_i + {29'd0, r_issue};
                    if (w_is_store) begin
                        mem_dout_o = rd_data_i[{r_issue[1:0], 3'b000} +: 8];
                    end
                end
                c_S_WAIT: begin
                    stall_req_o = 1'b1;
                    rd_addr_o   = rd_addr_i;
                end
                c_S_DONE: begin
                    rd_addr_o = rd_addr_i;
                    if (w_is_load) begin
                        rd_data_o   = w_load_ext;
                        rd_enable_o = rd_enable_i;
                    end
                end
                default: begin
                    stall_req_o = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: directed vector table,
//                hand-written reset/pass-through sequences and randomized ops
//                against a byte-array memory reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = c_OP_NOP;
    logic [31:0] rd_data_i = 32'd0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        rd_enable_i = 1'b0;
    logic [31:0] mem_addr_i = 32'd0;
    logic        stall_i = 1'b0;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i = 8'd0;
    logic        mem_gnt_i = 1'b1;

    mem_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .rd_data_i(rd_data_i),
        .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i), .mem_addr_i(mem_addr_i),
        .stall_i(stall_i), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
        .rd_enable_o(rd_enable_o), .stall_req_o(stall_req_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o),
        .mem_din_i(mem_din_i), .mem_gnt_i(mem_gnt_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Byte-addressed memory model; unwritten bytes read back a fixed pattern.
    logic [7:0]  mem [logic [31:0]];
    int          write_count = 0;
    logic [7:0]  next_din = 8'd0;

    // Per-operation bookkeeping used by the memory responder.
    logic [7:0]  cur_op;
    logic [31:0] cur_base;
    logic [31:0] cur_data;
    int          granted, denied, deny_at, deny_left;
    bit          rnd_gnt;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pre;
        int          deny_at;
        int          deny_n;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_en;
        int          exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int ref_size(input logic [7:0] op);
        case (op)
            c_OP_LB, c_OP_LBU, c_OP_SB: return 1;
            c_OP_LH, c_OP_LHU, c_OP_SH: return 2;
            c_OP_LW, c_OP_SW:           return 4;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit ref_is_store(input logic [7:0] op);
        return (op == c_OP_SB) || (op == c_OP_SH) || (op == c_OP_SW);
    endfunction

    // Value a load should deliver, built from the memory contents as a number.
    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr);
        logic [31:0] val;
        logic [7:0]  b;
        logic [15:0] h;
        val = 32'd0;
        for (int k = 0; k < ref_size(op); k++)
            val = val + (32'(mrd(addr + 32'(k))) << (8 * k));
        b = val[7:0];
        h = val[15:0];
        if (op == c_OP_LB) val = {{24{b[7]}}, b};
        if (op == c_OP_LH) val = {{16{h[15]}}, h};
        return val;
    endfunction

    task automatic set_gnt();
        if (rnd_gnt) mem_gnt_i = ($urandom_range(0, 3) != 0);
        else         mem_gnt_i = !(granted == deny_at && deny_left > 0);
    endtask

    // Memory responder, run at the sampling point of each cycle.
    task automatic service();
        logic [31:0] sh;
        if (mem_req_o) begin
            chk("req_addr", mem_a_o, cur_base + 32'(granted));
            chk("req_we", {31'd0, mem_we_o}, {31'd0, ref_is_store(cur_op)});
            if (ref_is_store(cur_op)) begin
                sh = cur_data >> (8 * granted);
                chk("req_wdata", {24'd0, mem_dout_o}, {24'd0, sh[7:0]});
            end
            if (mem_gnt_i) begin
                if (mem_we_o) begin
                    mem[mem_a_o] = mem_dout_o;
                    write_count++;
                end else begin
                    next_din = mrd(mem_a_o);
                end
                granted++;
            end else begin
                denied++;
                if (!rnd_gnt && deny_left > 0) deny_left--;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_din_i = next_din;
        set_gnt();
    endtask

    // Present one memory op, run it to DONE, optionally hold DONE, then release.
    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic en_in, input logic [4:0] raddr, input int dat, input int dn,
                         input bit rnd, input int hold, output logic [31:0] res,
                         output logic res_en, output logic [4:0] res_addr, output int stalls);
        bit done;
        int wc;
        cur_op = op; cur_base = addr; cur_data = data;
        granted = 0; denied = 0; deny_at = dat; deny_left = dn; rnd_gnt = rnd;
        aluop_i = op; mem_addr_i = addr; rd_data_i = data;
        rd_enable_i = en_in; rd_addr_i = raddr;
        set_gnt();
        stalls = 0; done = 0; res = 32'd0; res_en = 1'b0; res_addr = 5'd0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (stall_req_o) begin
                stalls++;
            end else begin
                done = 1;
                res = rd_data_o; res_en = rd_enable_o; res_addr = rd_addr_o;
            end
            service();
            if (!done) tick();
        end
        if (!done) chk("op_timeout", 32'd1, 32'd0);
        wc = write_count;
        if (hold > 0) begin
            stall_i = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick();
                @(negedge clk);
                chk("hold_req", {31'd0, mem_req_o}, 32'd0);
                chk("hold_stall", {31'd0, stall_req_o}, 32'd0);
                chk("hold_data", rd_data_o, res);
                service();
            end
            stall_i = 1'b0;
            chk("hold_writes", 32'(write_count), 32'(wc));
        end
        tick();
        aluop_i = c_OP_NOP;
        rd_enable_i = 1'b0;
    endtask

    task automatic pass_op(input logic [31:0] data, input logic [4:0] raddr, input logic en_in);
        aluop_i = c_OP_ADD; rd_data_i = data; rd_addr_i = raddr; rd_enable_i = en_in;
        #1;
        chk("pass_data", rd_data_o, data);
        chk("pass_addr", {27'd0, rd_addr_o}, {27'd0, raddr});
        chk("pass_en", {31'd0, rd_enable_o}, {31'd0, en_in});
        chk("pass_stall", {31'd0, stall_req_o}, 32'd0);
        chk("pass_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        service();
        tick();
        aluop_i = c_OP_NOP;
    endtask

    vec_t vecs[9];
    logic [7:0] op_list[9];

    initial begin
        logic [31:0] res, sh;
        logic        res_en;
        logic [4:0]  res_addr;
        int          stalls, wc, sz;
        logic [31:0] exp;

        vecs[0] = '{c_OP_LW,  32'h0000_0100, 32'h0,         32'h4433_2211, 0, 0, 0, 32'h4433_2211, 1'b1, 6};
        vecs[1] = '{c_OP_LB,  32'h0000_0080, 32'h0,         32'h0000_0080, 0, 0, 0, 32'hFFFF_FF80, 1'b1, 3};
        vecs[2] = '{c_OP_LBU, 32'h0000_0080, 32'h0,         32'h0000_0080, 0, 0, 0, 32'h0000_0080, 1'b1, 3};
        vecs[3] = '{c_OP_LHU, 32'h0000_0202, 32'h0,         32'h0000_BEEF, 0, 0, 0, 32'h0000_BEEF, 1'b1, 4};
        vecs[4] = '{c_OP_SH,  32'h0000_0202, 32'h1234_BEEF, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 1'b0, 3};
        vecs[5] = '{c_OP_LW,  32'h0000_0400, 32'h0,         32'hDDCC_BBAA, 1, 3, 0, 32'hDDCC_BBAA, 1'b1, 9};
        vecs[6] = '{c_OP_SB,  32'h0000_0500, 32'h0000_00A5, 32'h0000_0000, 0, 0, 2, 32'h0000_0000, 1'b0, 2};
        vecs[7] = '{c_OP_LH,  32'h0000_0600, 32'h0,         32'h0000_8001, 0, 0, 0, 32'hFFFF_8001, 1'b1, 4};
        vecs[8] = '{c_OP_LW,  32'hFFFF_FFFE, 32'h0,         32'h8765_4321, 0, 0, 0, 32'h8765_4321, 1'b1, 6};
        op_list = '{c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU, c_OP_SB, c_OP_SH, c_OP_SW, c_OP_ADD};

        cur_op = c_OP_NOP; cur_base = 0; cur_data = 0;
        granted = 0; denied = 0; deny_at = 0; deny_left = 0; rnd_gnt = 0;

        // Reset state, with a memory op presented during reset.
        aluop_i = c_OP_LW; rd_enable_i = 1'b1; rd_data_i = 32'hDEAD_BEEF; rd_addr_i = 5'd7;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_data", rd_data_o, 32'd0);
        chk("rst_addr", {27'd0, rd_addr_o}, 32'd0);
        chk("rst_en", {31'd0, rd_enable_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_a", mem_a_o, 32'd0);
        chk("rst_dout", {24'd0, mem_dout_o}, 32'd0);
        @(posedge clk); #1;
        aluop_i = c_OP_NOP; rd_enable_i = 1'b0;
        rst = 1'b0;
        tick();

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            sh = vecs[i].pre;
            for (int k = 0; k < 4; k++) mem[vecs[i].addr + 32'(k)] = sh[8*k +: 8];
            wc = write_count;
            do_op(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1, 5'(i + 1), vecs[i].deny_at,
                  vecs[i].deny_n, 1'b0, vecs[i].hold, res, res_en, res_addr, stalls);
            chk($sformatf("vec%0d_data", i), res, vecs[i].exp_data);
            chk($sformatf("vec%0d_en", i), {31'd0, res_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("vec%0d_rdaddr", i), {27'd0, res_addr}, 32'(i + 1));
            chk($sformatf("vec%0d_stall", i), 32'(stalls), 32'(vecs[i].exp_stall));
            if (ref_is_store(vecs[i].op)) begin
                sz = ref_size(vecs[i].op);
                chk($sformatf("vec%0d_nwrites", i), 32'(write_count - wc), 32'(sz));
                sh = vecs[i].data;
                for (int k = 0; k < sz; k++)
                    chk($sformatf("vec%0d_mem%0d", i, k), {24'd0, mrd(vecs[i].addr + 32'(k))},
                        {24'd0, sh[8*k +: 8]});
            end
        end

        // Reset in the middle of SW after two granted bytes.
        for (int k = 0; k < 4; k++) mem[32'h300 + 32'(k)] = 8'h00;
        cur_op = c_OP_SW; cur_base = 32'h300; cur_data = 32'hA1B2_C3D4;
        granted = 0; denied = 0; deny_left = 0; rnd_gnt = 0;
        aluop_i = c_OP_SW; mem_addr_i = 32'h300; rd_data_i = 32'hA1B2_C3D4;
        set_gnt();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            service();
            tick();
        end
        chk("rstmid_granted", 32'(granted), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        service();
        tick();
        rst = 1'b0;
        aluop_i = c_OP_NOP;
        @(negedge clk);
        chk("rstmid_req", {31'd0, mem_req_o}, 32'd0);
        chk("rstmid_stall", {31'd0, stall_req_o}, 32'd0);
        service();
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            service();
        end
        chk("rstmid_b0", {24'd0, mrd(32'h300)}, 32'h0000_00D4);
        chk("rstmid_b1", {24'd0, mrd(32'h301)}, 32'h0000_00C3);
        chk("rstmid_b2", {24'd0, mrd(32'h302)}, 32'd0);
        chk("rstmid_b3", {24'd0, mrd(32'h303)}, 32'd0);
        tick();

        // Pass-through.
        pass_op(32'h1357_9BDF, 5'd19, 1'b1);
        pass_op(32'hFFFF_0000, 5'd0, 1'b0);

        // Randomized ops with random grant behaviour.
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  op;
            logic [31:0] addr, data;
            logic        en_in;
            logic [4:0]  raddr;
            op = op_list[$urandom_range(0, 8)];
            addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                               : (32'h1000 + 32'($urandom_range(0, 255)));
            data = $urandom;
            en_in = 1'($urandom_range(0, 1));
            raddr = 5'($urandom_range(0, 31));
            if (op == c_OP_ADD) begin
                pass_op(data, raddr, en_in);
            end else begin
                exp = ref_load(op, addr);
                wc = write_count;
                sz = ref_size(op);
                do_op(op, addr, data, en_in, raddr, 0, 0, 1'b1, $urandom_range(0, 2),
                      res, res_en, res_addr, stalls);
                chk("rnd_rdaddr", {27'd0, res_addr}, {27'd0, raddr});
                chk("rnd_stall", 32'(stalls), 32'(1 + sz + (ref_is_store(op) ? 0 : 1) + denied));
                if (ref_is_store(op)) begin
                    chk("rnd_st_data", res, 32'd0);
                    chk("rnd_st_en", {31'd0, res_en}, 32'd0);
                    chk("rnd_nwrites", 32'(write_count - wc), 32'(sz));
                    for (int k = 0; k < sz; k++)
                        chk("rnd_mem", {24'd0, mrd(addr + 32'(k))}, {24'd0, data[8*k +: 8]});
                end else begin
                    chk("rnd_ld_data", res, exp);
                    chk("rnd_ld_en", {31'd0, res_en}, {31'd0, en_in});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
